// File: rtl/ultrasonic_echo_timer_if.sv
// rtl/ultrasonic_echo_timer_if.sv - control/sample bundle between the ranger controller and the echo timer
//
// Signals
//   start, enable   controller -> timer  single-shot request / free-running enable
//   echo            pin -> timer         raw, asynchronous echo pin
//   trigger         timer -> pin         ranger trigger pulse
//   busy            timer -> controller  measurement cycle in progress
//   sample_valid    timer -> controller  one-cycle pulse, new sample_count/timeout
//   sample_count    timer -> controller  last echo width in clk cycles
//   timeout         timer -> controller  last sample timed out
// Modports
//   master  controller side (drives start/enable/echo)
//   slave   the echo timer
interface ultrasonic_echo_timer_if #(
    parameter int CNT_W = 24
);
    logic             start;
    logic             enable;
    logic             echo;
    logic             trigger;
    logic             busy;
    logic             sample_valid;
    logic [CNT_W-1:0] sample_count;
    logic             timeout;

    modport master (
        output start, enable, echo,
        input  trigger, busy, sample_valid, sample_count, timeout
    );

    modport slave (
        input  start, enable, echo,
        output trigger, busy, sample_valid, sample_count, timeout
    );
endinterface

// File: rtl/ultrasonic_echo_timer.sv
// rtl/ultrasonic_echo_timer.sv - HC-SR04 style trigger generator and echo pulse-width timer
//
// Ports
//   clk      in   system clock
//   reset_l  in   synchronous reset, active-low
//   bus      ultrasonic_echo_timer_if.slave
//            start/enable/echo in; trigger/busy/sample_valid/sample_count/timeout out
// Operation
//   IDLE -> TRIG (TRIG_CYCLES of trigger=1) -> WAIT_RISE -> MEASURE -> COOLDOWN -> IDLE.
//   A missing echo or an over-long echo produces an all-ones sample with timeout=1.
module ultrasonic_echo_timer #(
    parameter int TRIG_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES  = 1500000,
    parameter int COOLDOWN_CYCLES = 65536,
    parameter int CNT_W           = 24
) (
    input  logic                   clk,
    input  logic                   reset_l,
    ultrasonic_echo_timer_if.slave bus
);

    // The shared counter must cover the longest of the three timed phases.
    localparam int M1   = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int MAXC = (M1 > COOLDOWN_CYCLES) ? M1 : COOLDOWN_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MEAS_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_COOLDOWN
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic            echo_m, echo_s, echo_d;
    logic            rise, fall;
    logic            smp_ld, smp_to;
    logic            trigger_r, sample_valid_r, timeout_r;
    logic [CNT_W-1:0] sample_count_r;

    assign rise    = echo_s & ~echo_d;
    assign fall    = ~echo_s & echo_d;
    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        smp_ld  = 1'b0;
        smp_to  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (bus.start || bus.enable) begin
                    state_n = S_TRIG;
                end
            end
            S_TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_n = S_WAIT_RISE;
                    cnt_n   = '0;
                end
            end
            S_WAIT_RISE: begin
                if (rise) begin
                    // The rise cycle already has echo_s=1, so it is the first counted cycle.
                    state_n = S_MEASURE;
                    cnt_n   = CW'(1);
                end else if (cnt == WAIT_LAST) begin
                    state_n = S_COOLDOWN;
                    cnt_n   = '0;
                    smp_to  = 1'b1;
                end
            end
            S_MEASURE: begin
                if (fall) begin
                    state_n = S_COOLDOWN;
                    cnt_n   = '0;
                    smp_ld  = 1'b1;
                end else if (cnt == MEAS_MAX) begin
                    state_n = S_COOLDOWN;
                    cnt_n   = '0;
                    smp_to  = 1'b1;
                end else if (!echo_s) begin
                    cnt_n = cnt;
                end
            end
            S_COOLDOWN: begin
                if (cnt == COOL_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state          <= S_IDLE;
            cnt            <= '0;
            echo_m         <= 1'b0;
            echo_s         <= 1'b0;
            echo_d         <= 1'b0;
            trigger_r      <= 1'b0;
            sample_valid_r <= 1'b0;
            sample_count_r <= '0;
            timeout_r      <= 1'b0;
        end else begin
            echo_m         <= bus.echo;
            echo_s         <= echo_m;
            echo_d         <= echo_s;
            state          <= state_n;
            cnt            <= cnt_n;
            // Registered from the next state so the pin is glitch-free and aligned with TRIG.
            trigger_r      <= (state_n == S_TRIG);
            sample_valid_r <= smp_ld | smp_to;
            if (smp_ld) begin
                sample_count_r <= CNT_W'(cnt);
                timeout_r      <= 1'b0;
            end else if (smp_to) begin
                sample_count_r <= {CNT_W{1'b1}};
                timeout_r      <= 1'b1;
            end
        end
    end

    assign bus.trigger      = trigger_r;
    assign bus.busy         = (state != S_IDLE);
    assign bus.sample_valid = sample_valid_r;
    assign bus.sample_count = sample_count_r;
    assign bus.timeout      = timeout_r;

endmodule

// File: tb/tb_ultrasonic_echo_timer.sv
// tb/tb_ultrasonic_echo_timer.sv - scoreboard bench for ultrasonic_echo_timer
module tb_ultrasonic_echo_timer;

    localparam int TRIG    = 10;
    localparam int TMO     = 1000;
    localparam int COOL    = 64;
    localparam int CW      = 16;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          tmo;
    } smp_t;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    ultrasonic_echo_timer_if #(.CNT_W(CW)) bus();

    ultrasonic_echo_timer #(
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .COOLDOWN_CYCLES(COOL),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .reset_l(reset_l),
        .bus    (bus.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    smp_t sb_q[$];
    int   trig_run = 0;
    int   trig_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Sample monitor: every sample_valid pops one expected sample.
    always @(negedge clk) begin
        if (reset_l && bus.sample_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_sample: got count %0d timeout %0b, expected none at %0t",
                         bus.sample_count, bus.timeout, $time);
            end else begin
                smp_t e;
                e = sb_q.pop_front();
                chk("sample_count", 32'(bus.sample_count), 32'(e.count));
                chk("sample_timeout", 32'(bus.timeout), 32'(e.tmo));
            end
        end
    end

    // Trigger monitor: every complete trigger pulse must be TRIG cycles wide.
    always @(negedge clk) begin
        if (!reset_l) begin
            trig_run = 0;
        end else if (bus.trigger === 1'b1) begin
            trig_run++;
        end else if (trig_run != 0) begin
            chk("trigger_width", 32'(trig_run), 32'(TRIG));
            trig_cnt++;
            trig_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Returns at the first negedge with trigger=0 after a trigger pulse (first WAIT_RISE cycle).
    task automatic wait_trig_fall();
        int n;
        n = 0;
        while (bus.trigger !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        while (bus.trigger !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL trig_wait: got no complete trigger pulse, expected one within 300 cycles");
        end
    endtask

    // Counts negedges with sample_valid low before the one where it is high.
    task automatic wait_sv(output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            if (bus.sample_valid === 1'b1) break;
            cycles++;
            if (cycles > 3000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sv_wait: got no sample_valid, expected one within 3000 cycles");
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy !== 1'b0 && n < 3000);
        if (n >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_wait: got busy=1, expected idle within 3000 cycles");
        end
    endtask

    task automatic drive_echo(input int n);
        tick();
        bus.echo = 1'b1;
        repeat (n) tick();
        bus.echo = 1'b0;
    endtask

    initial begin
        int lat;
        int t0;
        bus.start  = 1'b0;
        bus.enable = 1'b0;
        bus.echo   = 1'b0;

        // Power-on reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_trigger", 32'(bus.trigger), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.sample_valid), 0);
        chk("rst_count", 32'(bus.sample_count), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        tick();
        reset_l = 1'b1;

        // Reset mid-TRIG
        pulse_start();
        repeat (3) tick();
        reset_l = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("midtrig_trigger", 32'(bus.trigger), 0);
        chk("midtrig_busy", 32'(bus.busy), 0);
        chk("midtrig_count", 32'(bus.sample_count), 0);
        chk("midtrig_timeout", 32'(bus.timeout), 0);
        tick();
        reset_l = 1'b1;

        // Single shot, no echo: trigger starts next cycle, timeout after TMO WAIT_RISE cycles
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_trigger_next", 32'(bus.trigger), 1);
        chk("start_busy", 32'(bus.busy), 1);
        sb_q.push_back('{count: 16'hFFFF, tmo: 1'b1});
        wait_trig_fall();
        wait_sv(lat);
        // First WAIT_RISE cycle was already consumed by wait_trig_fall.
        chk("wait_rise_timeout_len", 32'(lat), 32'(TMO - 1));
        repeat (COOL - 1) @(negedge clk);
        chk("busy_before_cool_end", 32'(bus.busy), 1);
        @(negedge clk);
        chk("busy_cool_end", 32'(bus.busy), 0);

        // Single shot, 300-cycle echo
        pulse_start();
        wait_trig_fall();
        sb_q.push_back('{count: 16'd300, tmo: 1'b0});
        drive_echo(300);
        wait_sv(lat);
        chk("echo_fall_latency", 32'(lat), 3);
        repeat (COOL - 1) @(negedge clk);
        chk("busy_300_before_end", 32'(bus.busy), 1);
        @(negedge clk);
        chk("busy_300_end", 32'(bus.busy), 0);

        // Free-running, three shots of 200, start pulses while busy ignored
        t0 = trig_cnt;
        tick();
        bus.enable = 1'b1;
        for (int s = 0; s < 3; s++) begin
            wait_trig_fall();
            sb_q.push_back('{count: 16'd200, tmo: 1'b0});
            drive_echo(200);
            if (s == 2) bus.enable = 1'b0;
            wait_sv(lat);
            pulse_start();
        end
        repeat (150) @(negedge clk);
        chk("freerun_idle", 32'(bus.busy), 0);
        chk("freerun_triggers", 32'(trig_cnt - t0), 3);

        // Echo already high before WAIT_RISE: no fresh rise, so timeout
        tick();
        bus.echo = 1'b1;
        pulse_start();
        sb_q.push_back('{count: 16'hFFFF, tmo: 1'b1});
        wait_trig_fall();
        wait_sv(lat);
        chk("held_high_timeout_len", 32'(lat), 32'(TMO - 1));
        tick();
        bus.echo = 1'b0;
        wait_idle();

        // Reset mid-MEASURE, then a clean sample
        pulse_start();
        wait_trig_fall();
        tick();
        bus.echo = 1'b1;
        repeat (50) tick();
        reset_l = 1'b0;
        repeat (2) tick();
        bus.echo = 1'b0;
        reset_l = 1'b1;
        @(negedge clk);
        chk("midmeas_busy", 32'(bus.busy), 0);
        chk("midmeas_count", 32'(bus.sample_count), 0);
        chk("midmeas_timeout", 32'(bus.timeout), 0);
        pulse_start();
        wait_trig_fall();
        sb_q.push_back('{count: 16'd123, tmo: 1'b0});
        drive_echo(123);
        wait_sv(lat);
        wait_idle();

        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
